final_layer_sequencer: RTL and testbench

Time-multiplexed controller and datapath for the BNN output layer. It accepts one binarized feature vector, streams each neuron's weights from an external synchronous weight memory CHUNK bits at a time, and accumulates XNOR-popcount scores. It tracks the running maximum and returns the winning class index through a valid/ready handshake. It replaces the fully parallel 10×196 XNOR/popcount array with one CHUNK-wide XNOR/popcount unit.

---
 rtl/final_layer_sequencer_if.sv | 44 ++++
 rtl/final_layer_sequencer.sv | 164 ++++++++++++++++
 tb/tb_final_layer_sequencer.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/final_layer_sequencer_if.sv
// ---------------------------------------------------------------------------
// final_layer_sequencer_if
//   Bundles the classify request stream, the weight-memory read port and the
//   result stream of the BNN output-layer sequencer.
//
//   Signals:
//     in_valid / in_ready / data_in      : feature vector request handshake
//     weight_rd_en / weight_addr         : synchronous weight memory read
//     weight_data                        : read data, one cycle after rd_en
//     out_valid / out_ready              : result handshake
//     answer / best_score                : winning class and its score
//
//   Modports:
//     slave  : the sequencer itself
//     master : the surrounding system (request source, memory, consumer)
// ---------------------------------------------------------------------------
interface final_layer_sequencer_if #(
    parameter int NUM_INPUTS  = 196,
    parameter int NUM_NEURONS = 10,
    parameter int CHUNK       = 28,
    parameter int ADDR_W      = $clog2(NUM_NEURONS * (NUM_INPUTS / CHUNK)),
    parameter int SCORE_W     = $clog2(NUM_INPUTS + 1)
);
    logic                  in_valid;
    logic                  in_ready;
    logic [NUM_INPUTS-1:0] data_in;
    logic                  weight_rd_en;
    logic [ADDR_W-1:0]     weight_addr;
    logic [CHUNK-1:0]      weight_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            answer;
    logic [SCORE_W-1:0]    best_score;

    modport slave (
        input  in_valid, data_in, weight_data, out_ready,
        output in_ready, weight_rd_en, weight_addr, out_valid, answer, best_score
    );

    modport master (
        output in_valid, data_in, weight_data, out_ready,
        input  in_ready, weight_rd_en, weight_addr, out_valid, answer, best_score
    );
endinterface

// File: rtl/final_layer_sequencer.sv
// ---------------------------------------------------------------------------
// final_layer_sequencer
//   Time-multiplexed BNN output layer. One feature vector is captured, each
//   neuron's weights are streamed CHUNK bits per cycle from an external
//   synchronous memory, XNOR-popcount scores are accumulated per neuron and
//   the strictly-greater running maximum selects the winning class (ties keep
//   the lower index).
//
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : final_layer_sequencer_if.slave (request, weight read, result)
// ---------------------------------------------------------------------------
module final_layer_sequencer #(
    parameter int NUM_INPUTS  = 196,
    parameter int NUM_NEURONS = 10,
    parameter int CHUNK       = 28,
    parameter int ADDR_W      = $clog2(NUM_NEURONS * (NUM_INPUTS / CHUNK)),
    parameter int SCORE_W     = $clog2(NUM_INPUTS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    final_layer_sequencer_if.slave  bus
);
    localparam int CHUNKS  = NUM_INPUTS / CHUNK;
    localparam int CHUNK_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam int PC_W    = $clog2(CHUNK + 1);

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(NUM_NEURONS * CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic logic [PC_W-1:0] popcount(input logic [CHUNK-1:0] v);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < CHUNK; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    state_t                state;
    logic [NUM_INPUTS-1:0] data_reg;
    logic [CHUNK_W-1:0]    chunk;
    logic [3:0]            neuron;
    logic                  rd_en;
    logic [ADDR_W-1:0]     addr;
    logic                  out_valid_r;

    logic [CHUNK_W-1:0]    chunk_p1;
    logic [3:0]            neuron_p1;
    logic                  vld_p1;

    logic [SCORE_W-1:0]    acc;
    logic [SCORE_W-1:0]    best_val;
    logic [3:0]            best_idx;

    logic [CHUNK-1:0]      feat_p1;
    logic [PC_W-1:0]       pc_p1;
    logic [SCORE_W-1:0]    pc_ext_p1;
    logic [SCORE_W-1:0]    total_p1;

    logic                  accept;

    assign accept = (state == IDLE) && bus.in_valid;

    assign bus.in_ready     = (state == IDLE);
    assign bus.weight_rd_en = rd_en;
    assign bus.weight_addr  = addr;
    assign bus.out_valid    = out_valid_r;
    assign bus.answer       = best_idx;
    assign bus.best_score   = best_val;

    // ---- stage p1: weight word arrives, XNOR-popcount against its slice ----
    assign feat_p1   = data_reg[int'(chunk_p1) * CHUNK +: CHUNK];
    assign pc_p1     = popcount(~(bus.weight_data ^ feat_p1));
    assign pc_ext_p1 = SCORE_W'(pc_p1);
    // Full neuron total on its last chunk; with a single chunk acc is stale.
    assign total_p1  = (CHUNKS == 1) ? pc_ext_p1 : acc + pc_ext_p1;

    // Feature vector is plain data: captured on accept, never reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            data_reg <= bus.data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            chunk       <= '0;
            neuron      <= '0;
            rd_en       <= 1'b0;
            addr        <= '0;
            out_valid_r <= 1'b0;
            chunk_p1    <= '0;
            neuron_p1   <= '0;
            vld_p1      <= 1'b0;
            acc         <= '0;
            best_val    <= '0;
            best_idx    <= '0;
        end else begin
            // ---- stage p0 -> p1: remember which word the memory returns next ----
            vld_p1    <= rd_en;
            chunk_p1  <= chunk;
            neuron_p1 <= neuron;

            // ---- stage p1 -> accumulate / compare ----
            if (vld_p1) begin
                if (chunk_p1 == '0) begin
                    acc <= pc_ext_p1;
                end else begin
                    acc <= acc + pc_ext_p1;
                end
                // Neuron 0 always seeds the maximum; later ones must beat it strictly.
                if (chunk_p1 == LAST_CHUNK && (total_p1 > best_val || neuron_p1 == '0)) begin
                    best_val <= total_p1;
                    best_idx <= neuron_p1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state    <= RUN;
                        rd_en    <= 1'b1;
                        addr     <= '0;
                        chunk    <= '0;
                        neuron   <= '0;
                        acc      <= '0;
                        best_val <= '0;
                        best_idx <= '0;
                    end
                end
                RUN: begin
                    if (addr == LAST_ADDR) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        addr <= addr + ADDR_W'(1);
                        if (chunk == LAST_CHUNK) begin
                            chunk  <= '0;
                            neuron <= neuron + 4'd1;
                        end else begin
                            chunk <= chunk + CHUNK_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    state       <= DONE;
                    out_valid_r <= 1'b1;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_r <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_final_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_final_layer_sequencer
//   Directed bench for final_layer_sequencer: a table of feature vectors with
//   per-neuron match counts and hand-derived winners, plus sequences for the
//   held-result, mid-run reset and back-to-back cases. Includes a behavioural
//   synchronous weight memory and a read-address monitor.
// ---------------------------------------------------------------------------
module tb_final_layer_sequencer;
    localparam int NI     = 196;
    localparam int NN     = 10;
    localparam int CH     = 28;
    localparam int CHUNKS = NI / CH;
    localparam int AW     = 7;
    localparam int SW     = 8;
    localparam int NV     = 8;

    localparam logic [NI-1:0] ONES = '1;
    localparam logic [NI-1:0] PA   = {7{28'hA5C3F01}};
    localparam logic [NI-1:0] PB   = {14{14'h2B6D}};

    typedef struct {
        logic [NI-1:0] data;
        int            ans;
        int            score;
    } vec_t;

    logic clock;
    logic reset;

    final_layer_sequencer_if #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .CHUNK(CH), .ADDR_W(AW), .SCORE_W(SW)
    ) bus ();

    final_layer_sequencer #(
        .NUM_INPUTS(NI), .NUM_NEURONS(NN), .CHUNK(CH), .ADDR_W(AW), .SCORE_W(SW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous weight memory: data one cycle after the read strobe.
    logic [CH-1:0] wmem [NN*CHUNKS];
    always @(posedge clock) begin
        if (bus.weight_rd_en) begin
            bus.weight_data <= wmem[bus.weight_addr];
        end
    end

    // Read monitor: counts strobe cycles, bursts, and out-of-sequence addresses.
    int  rd_cnt    = 0;
    int  rd_rises  = 0;
    int  addr_err  = 0;
    int  exp_addr  = 0;
    bit  prev_rd   = 1'b0;
    always @(negedge clock) begin
        if (bus.weight_rd_en) begin
            if (!prev_rd) begin
                exp_addr = 0;
                rd_rises++;
            end
            if (int'(bus.weight_addr) != exp_addr) addr_err++;
            exp_addr++;
            rd_cnt++;
        end
        prev_rd = bus.weight_rd_en;
    end

    int   checks = 0;
    int   errors = 0;
    vec_t tab  [NV];
    int   mtab [NV][NN];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Neuron n's weights = data with the low (NI - m) bits inverted -> m matches.
    task automatic load_row(input int row);
        logic [NI-1:0] w;
        for (int n = 0; n < NN; n++) begin
            w = tab[row].data ^ (ONES >> mtab[row][n]);
            for (int c = 0; c < CHUNKS; c++) wmem[n*CHUNKS + c] = w[c*CH +: CH];
        end
    endtask

    task automatic run_vec(input int v, input bit hold);
        int lat;
        int r0, rr0, ae0;
        load_row(v);
        r0 = rd_cnt; rr0 = rd_rises; ae0 = addr_err;
        @(negedge clock);
        check($sformatf("v%0d_in_ready_idle", v), int'(bus.in_ready), 1);
        bus.data_in  = tab[v].data;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        bus.data_in  = '0;
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clock);
            lat++;
            #1;
        end
        check($sformatf("v%0d_latency", v), lat, 71);
        check($sformatf("v%0d_answer", v), int'(bus.answer), tab[v].ans);
        check($sformatf("v%0d_score", v), int'(bus.best_score), tab[v].score);
        check($sformatf("v%0d_in_ready_busy", v), int'(bus.in_ready), 0);
        check($sformatf("v%0d_read_cycles", v), rd_cnt - r0, 70);
        check($sformatf("v%0d_read_bursts", v), rd_rises - rr0, 1);
        check($sformatf("v%0d_addr_seq_errs", v), addr_err - ae0, 0);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clock);
                check("hold_out_valid", int'(bus.out_valid), 1);
                check("hold_answer", int'(bus.answer), tab[v].ans);
                check("hold_score", int'(bus.best_score), tab[v].score);
                check("hold_in_ready", int'(bus.in_ready), 0);
                bus.in_valid = (i % 2 == 0);
                bus.data_in  = ONES;
            end
            bus.in_valid = 1'b0;
        end
        @(negedge clock);
        bus.out_ready = 1'b1;
        @(posedge clock);
        #1;
        bus.out_ready = 1'b0;
        check($sformatf("v%0d_out_valid_after_hs", v), int'(bus.out_valid), 0);
        check($sformatf("v%0d_in_ready_after_hs", v), int'(bus.in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NI-1:0] bdat [3];
        int            bexp [3];
        int            acc_cyc [3];
        int            na, nb, cyc;
        logic [NI-1:0] w;

        tab[0] = '{data: ONES, ans: 3, score: 196};
        mtab[0] = '{0, 0, 0, 196, 0, 0, 0, 0, 0, 0};
        tab[1] = '{data: PA, ans: 0, score: 196};
        mtab[1] = '{196, 196, 196, 196, 196, 196, 196, 196, 196, 196};
        tab[2] = '{data: PB, ans: 9, score: 109};
        mtab[2] = '{100, 101, 102, 103, 104, 105, 106, 107, 108, 109};
        tab[3] = '{data: PA, ans: 0, score: 0};
        mtab[3] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tab[4] = '{data: PB, ans: 2, score: 150};
        mtab[4] = '{20, 20, 150, 20, 20, 20, 20, 150, 20, 20};
        tab[5] = '{data: ONES, ans: 0, score: 180};
        mtab[5] = '{180, 179, 178, 177, 176, 175, 174, 173, 172, 171};
        tab[6] = '{data: PA, ans: 9, score: 51};
        mtab[6] = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 51};
        tab[7] = '{data: PB, ans: 9, score: 1};
        mtab[7] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

        bus.in_valid  = 1'b0;
        bus.data_in   = '0;
        bus.out_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_rd_en", int'(bus.weight_rd_en), 0);
        check("rst_addr", int'(bus.weight_addr), 0);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_answer", int'(bus.answer), 0);
        check("rst_score", int'(bus.best_score), 0);
        reset = 1'b0;

        // Table: vector 0 also exercises a held result with in_valid pulsing.
        for (int v = 0; v < NV; v++) run_vec(v, v == 0);

        // Reset in the middle of a run (cycle 30 after accept).
        load_row(2);
        @(negedge clock);
        bus.data_in  = tab[2].data;
        bus.in_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.in_valid = 1'b0;
        repeat (29) @(posedge clock);
        #2;
        check("pre_rst_rd_en", int'(bus.weight_rd_en), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_rd_en", int'(bus.weight_rd_en), 0);
        check("mid_rst_addr", int'(bus.weight_addr), 0);
        check("mid_rst_in_ready", int'(bus.in_ready), 1);
        check("mid_rst_out_valid", int'(bus.out_valid), 0);
        check("mid_rst_answer", int'(bus.answer), 0);
        check("mid_rst_score", int'(bus.best_score), 0);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        run_vec(4, 1'b0);

        // Back-to-back: neuron n weights = ONES >> (10+15n); data = a neuron's weights.
        for (int n = 0; n < NN; n++) begin
            w = ONES >> (10 + 15 * n);
            for (int c = 0; c < CHUNKS; c++) wmem[n*CHUNKS + c] = w[c*CH +: CH];
        end
        bexp[0] = 5; bexp[1] = 0; bexp[2] = 9;
        for (int k = 0; k < 3; k++) begin
            bdat[k] = ONES >> (10 + 15 * bexp[k]);
            acc_cyc[k] = 0;
        end
        na = 0; nb = 0; cyc = 0;
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.data_in  = bdat[0];
        bus.in_valid = 1'b1;
        while (nb < 3 && cyc < 400) begin
            if (bus.in_ready && bus.in_valid) begin
                acc_cyc[na] = cyc;
                na++;
                @(posedge clock);
                #1;
                if (na < 3) begin
                    bus.data_in = bdat[na];
                end else begin
                    bus.in_valid = 1'b0;
                    bus.data_in  = '0;
                end
            end else if (bus.out_valid) begin
                check($sformatf("b2b%0d_answer", nb), int'(bus.answer), bexp[nb]);
                check($sformatf("b2b%0d_score", nb), int'(bus.best_score), 196);
                nb++;
            end
            @(negedge clock);
            cyc++;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("b2b_results", nb, 3);
        check("b2b_accepts", na, 3);
        check("b2b_spacing_01", acc_cyc[1] - acc_cyc[0], 73);
        check("b2b_spacing_12", acc_cyc[2] - acc_cyc[1], 73);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
